// File: rtl/controle_pkg.sv
// Shared state encoding and elaboration-time sizing helpers for the
// memory-sequence game controller.
package controle_pkg;

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        MOSTRA_ON   = 4'h2,
        MOSTRA_GAP  = 4'h3,
        ESPERA      = 4'h4,
        REGISTRA    = 4'h5,
        COMPARA     = 4'h6,
        PROXIMO     = 4'h7,
        PROX_RODADA = 4'h8,
        PERDE_VIDA  = 4'h9,
        FIM_ACERTOU = 4'hA,
        FIM_ERROU   = 4'hE,
        FIM_TIMEOUT = 4'hF
    } estado_t;

    // ceil(log2(v)), never below 1 so a degenerate count still gets a real bit
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/temporizador_param.sv
// Free-running up-counter with synchronous clear and a terminal-count flag
// compared against a caller-selected terminal value.
module temporizador_param #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         limpa_i,
    input  logic         conta_i,
    input  logic [W-1:0] fim_val_i,
    output logic         fim_o
);

    logic [W-1:0] valor_q;

    always_ff @(posedge clock) begin
        if (reset || limpa_i) begin
            valor_q <= '0;
        end else if (conta_i) begin
            valor_q <= valor_q + 1'b1;
        end
    end

    assign fim_o = (valor_q == fim_val_i);

endmodule

// File: rtl/controle_sequencia.sv
// Controller for a memory-sequence game: shows a growing sequence on LEDs,
// checks the player's button presses, and tracks rounds, lives and timeout.
module controle_sequencia
    import controle_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 5000,
    parameter int LED_ON_CYC  = 1000,
    parameter int LED_GAP_CYC = 250,
    parameter int LIVES       = 3
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               iniciar,
    input  logic                               modo,
    input  logic [ADDR_W-1:0]                  nivel,
    input  logic [N_CH-1:0]                    botoes,
    input  logic [N_CH-1:0]                    dado_mem,
    output logic [ADDR_W-1:0]                  endereco,
    output logic [N_CH-1:0]                    leds,
    output logic [ADDR_W-1:0]                  rodada,
    output logic [clog2_min1(LIVES+1)-1:0]     vidas,
    output logic                               acertou,
    output logic                               errou,
    output logic                               timeout_o,
    output logic                               pronto,
    output logic [3:0]                         db_estado
);

    localparam int TW = clog2_min1(max3(TIMEOUT_CYC, LED_ON_CYC, LED_GAP_CYC));
    localparam int VW = clog2_min1(LIVES + 1);
    localparam logic [TW-1:0] T_ON  = TW'(LED_ON_CYC - 1);
    localparam logic [TW-1:0] T_GAP = TW'(LED_GAP_CYC - 1);
    localparam logic [TW-1:0] T_TO  = TW'(TIMEOUT_CYC - 1);

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] rodada_q, rodada_d;
    logic [ADDR_W-1:0] endereco_q, endereco_d;
    logic [ADDR_W-1:0] limite_q, limite_d;
    logic [VW-1:0]     vidas_q, vidas_d;
    logic [N_CH-1:0]   jogada_q, jogada_d;
    logic [N_CH-1:0]   botoes_ant_q;
    logic [TW-1:0]     fim_val;
    logic              tempo_fim;
    logic              jogada;
    logic              igual;

    // One timer serves display on/off and the play timeout; it restarts on
    // every state change so each timed state begins counting from zero.
    always_comb begin
        fim_val = T_TO;
        case (estado_q)
            MOSTRA_ON:  fim_val = T_ON;
            MOSTRA_GAP: fim_val = T_GAP;
            default:    fim_val = T_TO;
        endcase
    end

    temporizador_param #(.W(TW)) u_temporizador (
        .clock     (clock),
        .reset     (reset),
        .limpa_i   (estado_d != estado_q),
        .conta_i   (1'b1),
        .fim_val_i (fim_val),
        .fim_o     (tempo_fim)
    );

    assign jogada = (|botoes) && (botoes_ant_q == '0);
    assign igual  = (jogada_q == dado_mem);

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q     <= INICIAL;
            rodada_q     <= '0;
            endereco_q   <= '0;
            limite_q     <= '0;
            vidas_q      <= '0;
            jogada_q     <= '0;
            botoes_ant_q <= '0;
        end else begin
            estado_q     <= estado_d;
            rodada_q     <= rodada_d;
            endereco_q   <= endereco_d;
            limite_q     <= limite_d;
            vidas_q      <= vidas_d;
            jogada_q     <= jogada_d;
            botoes_ant_q <= botoes;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        rodada_d   = rodada_q;
        endereco_d = endereco_q;
        limite_d   = limite_q;
        vidas_d    = vidas_q;
        jogada_d   = jogada_q;
        case (estado_q)
            INICIAL: if (iniciar) estado_d = PREPARA;
            PREPARA: begin
                rodada_d   = '0;
                endereco_d = '0;
                vidas_d    = VW'(LIVES);
                limite_d   = nivel;
                estado_d   = MOSTRA_ON;
            end
            MOSTRA_ON: if (tempo_fim) estado_d = MOSTRA_GAP;
            MOSTRA_GAP: begin
                if (tempo_fim) begin
                    if (endereco_q == rodada_q) begin
                        endereco_d = '0;
                        estado_d   = ESPERA;
                    end else begin
                        endereco_d = endereco_q + 1'b1;
                        estado_d   = MOSTRA_ON;
                    end
                end
            end
            ESPERA: begin
                if (tempo_fim) begin
                    estado_d = FIM_TIMEOUT;
                end else if (jogada) begin
                    jogada_d = botoes;
                    estado_d = REGISTRA;
                end
            end
            REGISTRA: estado_d = COMPARA;
            COMPARA: begin
                if (!igual)                       estado_d = PERDE_VIDA;
                else if (endereco_q != rodada_q)  estado_d = PROXIMO;
                else if (rodada_q == limite_q)    estado_d = FIM_ACERTOU;
                else                              estado_d = PROX_RODADA;
            end
            PROXIMO: begin
                endereco_d = endereco_q + 1'b1;
                estado_d   = ESPERA;
            end
            PROX_RODADA: begin
                rodada_d   = rodada_q + 1'b1;
                endereco_d = modo ? '0 : rodada_q + 1'b1;
                estado_d   = MOSTRA_ON;
            end
            PERDE_VIDA: begin
                vidas_d = vidas_q - 1'b1;
                if (vidas_q == VW'(1)) begin
                    estado_d = FIM_ERROU;
                end else begin
                    endereco_d = modo ? '0 : rodada_q;
                    estado_d   = MOSTRA_ON;
                end
            end
            FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: if (iniciar) estado_d = PREPARA;
            default: estado_d = INICIAL;
        endcase
    end

    assign endereco  = endereco_q;
    assign rodada    = rodada_q;
    assign vidas     = vidas_q;
    assign leds      = (estado_q == MOSTRA_ON) ? dado_mem : '0;
    assign acertou   = (estado_q == FIM_ACERTOU);
    assign errou     = (estado_q == FIM_ERROU);
    assign timeout_o = (estado_q == FIM_TIMEOUT);
    assign pronto    = acertou || errou || timeout_o;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_controle_sequencia.sv
// Scoreboard bench: each scenario queues the hand-derived sequence of state
// entries; a monitor pops one entry on every db_estado change and compares.
module tb_controle_sequencia;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iniciar = 1'b0;
    logic       modo = 1'b1;
    logic [1:0] nivel = '0;
    logic [3:0] botoes = '0;
    logic [3:0] dado_mem;
    logic [1:0] endereco;
    logic [3:0] leds;
    logic [1:0] rodada;
    logic [1:0] vidas;
    logic       acertou, errou, timeout_o, pronto;
    logic [3:0] db_estado;

    logic [3:0] mem [4];
    assign dado_mem = mem[endereco];

    always #5 clk = ~clk;

    controle_sequencia #(
        .N_CH(4), .ADDR_W(2), .TIMEOUT_CYC(20),
        .LED_ON_CYC(4), .LED_GAP_CYC(2), .LIVES(2)
    ) dut (
        .clock(clk), .reset(rst), .iniciar(iniciar), .modo(modo),
        .nivel(nivel), .botoes(botoes), .dado_mem(dado_mem),
        .endereco(endereco), .leds(leds), .rodada(rodada), .vidas(vidas),
        .acertou(acertou), .errou(errou), .timeout_o(timeout_o),
        .pronto(pronto), .db_estado(db_estado)
    );

    typedef struct {
        logic [3:0] est;
        logic [3:0] leds;
        logic [1:0] rod;
        logic [1:0] endr;
        logic [1:0] vid;
        logic [3:0] flg;
        int         dwell;
    } item_t;

    item_t q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    bit    mon_en = 1'b0;

    // est, leds, rodada, endereco, vidas, {acertou,errou,timeout,pronto},
    // cycles spent in the state being left (-1 = not checked)
    task automatic ex(input logic [3:0] est, input logic [3:0] l, input logic [1:0] r,
                      input logic [1:0] e, input logic [1:0] v, input logic [3:0] f,
                      input int dw);
        item_t it;
        it.est = est; it.leds = l; it.rod = r; it.endr = e;
        it.vid = v; it.flg = f; it.dwell = dw;
        q.push_back(it);
    endtask

    initial begin : monitor
        logic [3:0] last;
        int         cnt;
        int         ev;
        item_t      it;
        wait (mon_en);
        last = 4'h0;
        cnt  = 0;
        ev   = 0;
        forever begin
            @(negedge clk);
            if (db_estado != last) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_event: got est=%h leds=%b rod=%0d end=%0d vid=%0d, required no state change",
                             db_estado, leds, rodada, endereco, vidas);
                end else begin
                    it = q.pop_front();
                    if (db_estado !== it.est || leds !== it.leds || rodada !== it.rod ||
                        endereco !== it.endr || vidas !== it.vid ||
                        {acertou, errou, timeout_o, pronto} !== it.flg ||
                        (it.dwell >= 0 && cnt != it.dwell)) begin
                        n_err++;
                        $display("FAIL event%0d: got est=%h leds=%b rod=%0d end=%0d vid=%0d flg=%b dwell=%0d, required est=%h leds=%b rod=%0d end=%0d vid=%0d flg=%b dwell=%0d",
                                 ev, db_estado, leds, rodada, endereco, vidas,
                                 {acertou, errou, timeout_o, pronto}, cnt,
                                 it.est, it.leds, it.rod, it.endr, it.vid, it.flg, it.dwell);
                    end
                end
                ev++;
                last = db_estado;
                cnt  = 1;
            end else begin
                cnt++;
            end
        end
    end

    task automatic wait_state(input logic [3:0] s);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (db_estado == s) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL wait_state: got est=%h after 300 cycles, required est=%h", db_estado, s);
    endtask

    task automatic press(input logic [3:0] v, input int hold);
        botoes = v;
        repeat (hold) @(negedge clk);
        botoes = '0;
    endtask

    task automatic pulse_iniciar();
        iniciar = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
    endtask

    task automatic chk_reset(input string nome);
        n_cmp++;
        if (db_estado !== 4'h0 || leds !== '0 || rodada !== '0 || endereco !== '0 ||
            vidas !== '0 || {acertou, errou, timeout_o, pronto} !== 4'b0) begin
            n_err++;
            $display("FAIL %s: got est=%h leds=%b rod=%0d end=%0d vid=%0d flg=%b, required all zero",
                     nome, db_estado, leds, rodada, endereco, vidas,
                     {acertou, errou, timeout_o, pronto});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[0] = 4'b0001; mem[1] = 4'b0100; mem[2] = 4'b1000; mem[3] = 4'b0010;
        repeat (3) @(negedge clk);
        chk_reset("reset_state");
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Full win, replay mode, two rounds
        modo = 1'b1; nivel = 2'd1;
        ex(4'h1,4'b0000,0,0,0,4'b0000,-1); ex(4'h2,4'b0001,0,0,2,4'b0000,1);
        ex(4'h3,4'b0000,0,0,2,4'b0000,4);  ex(4'h4,4'b0000,0,0,2,4'b0000,2);
        ex(4'h5,4'b0000,0,0,2,4'b0000,-1); ex(4'h6,4'b0000,0,0,2,4'b0000,1);
        ex(4'h8,4'b0000,0,0,2,4'b0000,1);
        ex(4'h2,4'b0001,1,0,2,4'b0000,1);  ex(4'h3,4'b0000,1,0,2,4'b0000,4);
        ex(4'h2,4'b0100,1,1,2,4'b0000,2);  ex(4'h3,4'b0000,1,1,2,4'b0000,4);
        ex(4'h4,4'b0000,1,0,2,4'b0000,2);
        ex(4'h5,4'b0000,1,0,2,4'b0000,-1); ex(4'h6,4'b0000,1,0,2,4'b0000,1);
        ex(4'h7,4'b0000,1,0,2,4'b0000,1);  ex(4'h4,4'b0000,1,1,2,4'b0000,1);
        ex(4'h5,4'b0000,1,1,2,4'b0000,-1); ex(4'h6,4'b0000,1,1,2,4'b0000,1);
        ex(4'hA,4'b0000,1,1,2,4'b1001,1);
        pulse_iniciar();
        wait_state(4'h4); press(4'b0001, 1);
        wait_state(4'h4); press(4'b0001, 1);
        wait_state(4'h4); press(4'b0100, 1);
        wait_state(4'hA);

        // Two wrong presses exhaust both lives
        ex(4'h1,4'b0000,1,1,2,4'b0000,-1); ex(4'h2,4'b0001,0,0,2,4'b0000,1);
        ex(4'h3,4'b0000,0,0,2,4'b0000,4);  ex(4'h4,4'b0000,0,0,2,4'b0000,2);
        ex(4'h5,4'b0000,0,0,2,4'b0000,-1); ex(4'h6,4'b0000,0,0,2,4'b0000,1);
        ex(4'h9,4'b0000,0,0,2,4'b0000,1);  ex(4'h2,4'b0001,0,0,1,4'b0000,1);
        ex(4'h3,4'b0000,0,0,1,4'b0000,4);  ex(4'h4,4'b0000,0,0,1,4'b0000,2);
        ex(4'h5,4'b0000,0,0,1,4'b0000,-1); ex(4'h6,4'b0000,0,0,1,4'b0000,1);
        ex(4'h9,4'b0000,0,0,1,4'b0000,1);  ex(4'hE,4'b0000,0,0,0,4'b0101,1);
        pulse_iniciar();
        wait_state(4'h4); press(4'b0010, 1);
        wait_state(4'h4); press(4'b0010, 1);
        wait_state(4'hE);

        // Timeout with no press, then a press landing on the expiry cycle
        nivel = 2'd0;
        ex(4'h1,4'b0000,0,0,0,4'b0000,-1); ex(4'h2,4'b0001,0,0,2,4'b0000,1);
        ex(4'h3,4'b0000,0,0,2,4'b0000,4);  ex(4'h4,4'b0000,0,0,2,4'b0000,2);
        ex(4'hF,4'b0000,0,0,2,4'b0011,20);
        pulse_iniciar();
        wait_state(4'hF);
        ex(4'h1,4'b0000,0,0,2,4'b0000,-1); ex(4'h2,4'b0001,0,0,2,4'b0000,1);
        ex(4'h3,4'b0000,0,0,2,4'b0000,4);  ex(4'h4,4'b0000,0,0,2,4'b0000,2);
        ex(4'hF,4'b0000,0,0,2,4'b0011,20);
        pulse_iniciar();
        wait_state(4'h4);
        repeat (19) @(negedge clk);
        press(4'b0001, 1);
        wait_state(4'hF);

        // Newest-entry mode up to round 2, then a held button times out
        modo = 1'b0; nivel = 2'd2;
        ex(4'h1,4'b0000,0,0,2,4'b0000,-1); ex(4'h2,4'b0001,0,0,2,4'b0000,1);
        ex(4'h3,4'b0000,0,0,2,4'b0000,4);  ex(4'h4,4'b0000,0,0,2,4'b0000,2);
        ex(4'h5,4'b0000,0,0,2,4'b0000,-1); ex(4'h6,4'b0000,0,0,2,4'b0000,1);
        ex(4'h8,4'b0000,0,0,2,4'b0000,1);
        ex(4'h2,4'b0100,1,1,2,4'b0000,1);  ex(4'h3,4'b0000,1,1,2,4'b0000,4);
        ex(4'h4,4'b0000,1,0,2,4'b0000,2);
        ex(4'h5,4'b0000,1,0,2,4'b0000,-1); ex(4'h6,4'b0000,1,0,2,4'b0000,1);
        ex(4'h7,4'b0000,1,0,2,4'b0000,1);  ex(4'h4,4'b0000,1,1,2,4'b0000,1);
        ex(4'h5,4'b0000,1,1,2,4'b0000,-1); ex(4'h6,4'b0000,1,1,2,4'b0000,1);
        ex(4'h8,4'b0000,1,1,2,4'b0000,1);
        ex(4'h2,4'b1000,2,2,2,4'b0000,1);  ex(4'h3,4'b0000,2,2,2,4'b0000,4);
        ex(4'h4,4'b0000,2,0,2,4'b0000,2);
        ex(4'h5,4'b0000,2,0,2,4'b0000,-1); ex(4'h6,4'b0000,2,0,2,4'b0000,1);
        ex(4'h7,4'b0000,2,0,2,4'b0000,1);  ex(4'h4,4'b0000,2,1,2,4'b0000,1);
        ex(4'hF,4'b0000,2,1,2,4'b0011,20);
        pulse_iniciar();
        wait_state(4'h4); press(4'b0001, 1);
        wait_state(4'h4); press(4'b0001, 1);
        wait_state(4'h4); press(4'b0100, 1);
        wait_state(4'h4); press(4'b0001, 30);
        wait_state(4'hF);

        // Multi-button press costs a life; reset (with iniciar high) mid-display
        modo = 1'b1; nivel = 2'd1;
        ex(4'h1,4'b0000,2,1,2,4'b0000,-1); ex(4'h2,4'b0001,0,0,2,4'b0000,1);
        ex(4'h3,4'b0000,0,0,2,4'b0000,4);  ex(4'h4,4'b0000,0,0,2,4'b0000,2);
        ex(4'h5,4'b0000,0,0,2,4'b0000,-1); ex(4'h6,4'b0000,0,0,2,4'b0000,1);
        ex(4'h9,4'b0000,0,0,2,4'b0000,1);  ex(4'h2,4'b0001,0,0,1,4'b0000,1);
        ex(4'h0,4'b0000,0,0,0,4'b0000,1);
        pulse_iniciar();
        wait_state(4'h4); press(4'b0011, 1);
        wait_state(4'h2);
        rst = 1'b1; iniciar = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("reset_mid_display");
        rst = 1'b0; iniciar = 1'b0;
        repeat (6) @(negedge clk);
        chk_reset("idle_after_reset");

        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending events, required 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/controle_sequencia.md
CONTROLE_SEQUENCIA -- requirements
Module: controle_sequencia

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of button/LED channels.
REQ-002 SHALL have parameter ADDR_W, default 4: sequence address width, giving up to 2^ADDR_W rounds.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 5000: cycles allowed per play.
REQ-004 SHALL have parameters LED_ON_CYC (1000) and LED_GAP_CYC (250): display on time and off time per entry.
REQ-005 SHALL have parameter LIVES, default 3, minimum 1: wrong plays tolerated before loss.
REQ-006 SHALL have port clock  in  1  the single clock, all logic on the rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port iniciar  in  1  start or restart request.
REQ-009 SHALL have port modo  in  1  replay mode: 1 replays the full sequence each round, 0 shows only the newest entry.
REQ-010 SHALL have port nivel  in  ADDR_W  index of the last round, sampled in PREPARA.
REQ-011 SHALL have port botoes  in  N_CH  button levels, already synchronised.
REQ-012 SHALL have port dado_mem  in  N_CH  one-hot expected value, read asynchronously from external memory at endereco.
REQ-013 SHALL have port endereco  out  ADDR_W  memory address.
REQ-014 SHALL have port leds  out  N_CH  display output.
REQ-015 SHALL have port rodada  out  ADDR_W  current round.
REQ-016 SHALL have port vidas  out  clog2(LIVES+1)  remaining lives.
REQ-017 SHALL have ports acertou, errou, timeout_o and pronto  out  1 each  end-of-game flags.
REQ-018 SHALL have port db_estado  out  4  state code.

Function
REQ-019 SHALL implement these states with these db_estado codes: INICIAL=0, PREPARA=1, MOSTRA_ON=2, MOSTRA_GAP=3, ESPERA=4, REGISTRA=5, COMPARA=6, PROXIMO=7, PROX_RODADA=8, PERDE_VIDA=9, FIM_ACERTOU=A, FIM_ERROU=E, FIM_TIMEOUT=F.
REQ-020 SHALL move from INICIAL to PREPARA on iniciar; PREPARA lasts 1 cycle, sets rodada=0, endereco=0, vidas=LIVES, latches nivel into limite, clears the timer, then goes to MOSTRA_ON.
REQ-021 SHALL, in MOSTRA_ON, drive leds=dado_mem for exactly LED_ON_CYC cycles, then go to MOSTRA_GAP.
REQ-022 SHALL, in MOSTRA_GAP, drive leds=0 for LED_GAP_CYC cycles; on expiry, if endereco==rodada it sets endereco=0, clears the timer and goes to ESPERA; otherwise it increments endereco and goes to MOSTRA_ON.
REQ-023 SHALL detect a play (jogada) when botoes!=0 and the previous-cycle botoes==0; a held button counts as a single play.
REQ-024 SHALL, in ESPERA, count one per cycle; the timer reaching TIMEOUT_CYC-1 goes to FIM_TIMEOUT; otherwise a jogada latches botoes into jogada_reg and goes to REGISTRA; timeout wins when both occur in the same cycle.
REQ-025 SHALL go from REGISTRA to COMPARA in 1 cycle; igual = (jogada_reg == dado_mem), so a multi-button press is wrong.
REQ-026 SHALL branch from COMPARA as follows: not igual goes to PERDE_VIDA; igual with endereco<rodada goes to PROXIMO; igual with endereco==rodada goes to FIM_ACERTOU if rodada==limite, else to PROX_RODADA.
REQ-027 SHALL, in PROXIMO, increment endereco, clear the timer and go to ESPERA.
REQ-028 SHALL, in PROX_RODADA, increment rodada and set endereco = modo ? 0 : rodada+1, then go to MOSTRA_ON.
REQ-029 SHALL, in PERDE_VIDA, decrement vidas; if the result is 0 it goes to FIM_ERROU, else it sets endereco = modo ? 0 : rodada and goes to MOSTRA_ON to replay the same round.
REQ-030 SHALL, in FIM_* states, assert pronto plus the matching flag (acertou, errou or timeout_o), hold leds=0, hold rodada and vidas, and go to PREPARA on iniciar.
REQ-031 SHALL keep all flags low outside their FIM state, and all outputs SHALL be registered or decoded from state only (Moore).
REQ-032 SHALL size the timer as clog2(max(TIMEOUT_CYC, LED_ON_CYC, LED_GAP_CYC)) bits; rodada and endereco SHALL never wrap, since limite ≤ 2^ADDR_W-1.

Reset
REQ-033 SHALL, when reset=1 at a clock edge (including mid-display or mid-play), enter INICIAL and zero endereco, leds, rodada, vidas, the timer, jogada_reg, the previous-botoes register and every flag; db_estado=0.
REQ-034 SHALL ignore iniciar in any cycle where reset is asserted.

Structure
REQ-035 SHALL take the state codes and the clog2 width helper from a shared package controle_pkg.
REQ-036 SHALL use a single sub-module, temporizador_param (loadable clear/count, parametrised terminal value), instantiated once and shared by display and timeout.

Verification (N_CH=4, ADDR_W=2, TIMEOUT_CYC=20, LED_ON_CYC=4, LED_GAP_CYC=2, LIVES=2)
REQ-037 SHALL cover reset: pulse reset -> all outputs 0, db_estado=0; assert reset during MOSTRA_ON -> INICIAL next edge, leds=0.
REQ-038 SHALL cover a full win: nivel=1, modo=1, memory {0001,0100}, correct presses -> round 0 shows one entry for 4 cycles, round 1 shows two entries, then acertou=1, pronto=1, db_estado=A.
REQ-039 SHALL cover lives: press 0010 when 0001 is expected -> vidas 2->1 and the round replays; a second wrong press -> errou=1, vidas=0, db_estado=E.
REQ-040 SHALL cover timeout: no press for 20 cycles in ESPERA -> timeout_o=1, db_estado=F; a press on the expiry cycle -> still FIM_TIMEOUT.
REQ-041 SHALL cover mode 0: modo=0, advance to round 2 -> only endereco=2 is displayed, then endereco=0 in ESPERA.
REQ-042 SHALL cover held and multi-button input: a button held over 30 cycles -> exactly one REGISTRA; 0011 pressed -> PERDE_VIDA.
